// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared types and constants for the PLL lock / reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      HOLD,
      RUN
   } pll_seq_state_e;

   localparam int unsigned          LOSS_CNT_W = 8;
   localparam logic [LOSS_CNT_W-1:0] LOSS_MAX   = 8'd255;

endpackage

// File: rtl/pll_lock_reset_seq_sync_bit.sv
// Generic N-flop single-bit synchroniser, all flops cleared by reset.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) r_sync <= '0;
      else            r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Qualifies the PLL locked flag and sequences PLL reset and memory-side reset.
// Runs from the free-running reference clock, never from a PLL output.
module pll_lock_reset_seq
   import pll_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES         = 2,
   parameter int unsigned PLL_RST_CYCLES      = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned RESET_HOLD_CYCLES   = 64,
   parameter int unsigned CNT_W               = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_locked_in,
   input  logic                  i_sw_reset_req,
   input  logic                  i_clear_count,
   output logic                  o_pll_rst,
   output logic                  o_mem_reset_n,
   output logic                  o_ready,
   output logic                  o_lock_lost,
   output logic [LOSS_CNT_W-1:0] o_loss_count
);

   localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);

   pll_seq_state_e            r_state;
   pll_seq_state_e            w_next_state;
   logic [CNT_W-1:0]          r_cnt;
   logic                      w_cnt_clr;
   logic                      w_loss;
   logic                      w_lock_s;
   logic                      r_pll_rst;
   logic                      r_mem_reset_n;
   logic                      r_ready;
   logic                      r_lock_lost;
   logic [LOSS_CNT_W-1:0]     r_loss_count;

   sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_d       (i_locked_in),
      .o_q       (w_lock_s)
   );

   // Next-state and lock-loss decode; software reset overrides everything.
   always_comb begin
      w_next_state = r_state;
      w_loss       = 1'b0;
      if (i_sw_reset_req) begin
         w_next_state = PLL_RST;
      end else begin
         case (r_state)
            PLL_RST:   if (r_cnt == C_RST_LAST) w_next_state = WAIT_LOCK;
            WAIT_LOCK: begin
               if (w_lock_s)                        w_next_state = STABLE;
               else if (r_cnt == C_TIMEOUT_LAST)    w_next_state = PLL_RST;
            end
            STABLE: begin
               if (!w_lock_s)                       w_next_state = WAIT_LOCK;
               else if (r_cnt == C_STABLE_LAST)     w_next_state = HOLD;
            end
            HOLD: begin
               if (!w_lock_s) begin
                  w_next_state = PLL_RST;
                  w_loss       = 1'b1;
               end else if (r_cnt == C_HOLD_LAST) begin
                  w_next_state = RUN;
               end
            end
            RUN: begin
               if (!w_lock_s) begin
                  w_next_state = PLL_RST;
                  w_loss       = 1'b1;
               end
            end
            default:                                w_next_state = PLL_RST;
         endcase
      end
      w_cnt_clr = i_sw_reset_req || (w_next_state != r_state);
   end

   // State, shared cycle counter and outputs; outputs decode the next state
   // so they change on the same edge as the state.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= PLL_RST;
         r_cnt         <= '0;
         r_pll_rst     <= 1'b1;
         r_mem_reset_n <= 1'b0;
         r_ready       <= 1'b0;
         r_lock_lost   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_cnt_clr)          r_cnt <= '0;
         else if (r_state != RUN) r_cnt <= r_cnt + 1'b1;
         r_pll_rst     <= (w_next_state == PLL_RST);
         r_mem_reset_n <= (w_next_state == RUN);
         r_ready       <= (w_next_state == RUN);
         r_lock_lost   <= w_loss;
      end
   end

   // Saturating lock-loss counter; clear wins over a simultaneous increment.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n)                                r_loss_count <= '0;
      else if (i_clear_count)                        r_loss_count <= '0;
      else if (w_loss && (r_loss_count != LOSS_MAX)) r_loss_count <= r_loss_count + 1'b1;
   end

   assign o_pll_rst     = r_pll_rst;
   assign o_mem_reset_n = r_mem_reset_n;
   assign o_ready       = r_ready;
   assign o_lock_lost   = r_lock_lost;
   assign o_loss_count  = r_loss_count;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed scenarios plus randomized lockstep
// against a behavioural model of the sequencing rules.
module tb_pll_lock_reset_seq;

   localparam int unsigned SYNC = 2, PRST = 3, TMO = 32, STB = 8, HLD = 4;
   localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_HOLD = 3, P_RUN = 4;

   logic clk = 1'b0, reset_n = 1'b0, locked_in = 1'b0, sw_reset_req = 1'b0, clear_count = 1'b0;
   logic pll_rst, mem_reset_n, ready, lock_lost;
   logic [7:0] loss_count;

   int n_cmp = 0, n_bad = 0;

   // behavioural model state
   int   m_phase = P_RST, m_el = 0, m_cnt = 0;
   logic m_pll = 1'b1, m_mrn = 1'b0, m_rdy = 1'b0, m_lost = 1'b0;
   logic m_sync[$];

   logic [11:0] dut_v, m_v;
   assign dut_v = {pll_rst, mem_reset_n, ready, lock_lost, loss_count};
   assign m_v   = {m_pll, m_mrn, m_rdy, m_lost, 8'(m_cnt)};

   pll_lock_reset_seq #(
      .SYNC_STAGES         (SYNC),
      .PLL_RST_CYCLES      (PRST),
      .LOCK_TIMEOUT_CYCLES (TMO),
      .LOCK_STABLE_CYCLES  (STB),
      .RESET_HOLD_CYCLES   (HLD),
      .CNT_W               (16)
   ) dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_locked_in    (locked_in),
      .i_sw_reset_req (sw_reset_req),
      .i_clear_count  (clear_count),
      .o_pll_rst      (pll_rst),
      .o_mem_reset_n  (mem_reset_n),
      .o_ready        (ready),
      .o_lock_lost    (lock_lost),
      .o_loss_count   (loss_count)
   );

   always #10 clk = ~clk;

   // Model of one clock edge, from the sequencing rules.
   task automatic m_step();
      logic ls;
      int   nxt;
      bit   loss;
      if (!reset_n) begin
         m_phase = P_RST; m_el = 0; m_pll = 1'b1; m_mrn = 1'b0; m_rdy = 1'b0;
         m_lost = 1'b0; m_cnt = 0;
         foreach (m_sync[i]) m_sync[i] = 1'b0;
         return;
      end
      ls = m_sync[SYNC-1];
      void'(m_sync.pop_back());
      m_sync.push_front(locked_in);
      nxt  = m_phase;
      loss = 1'b0;
      if (sw_reset_req) nxt = P_RST;
      else if (m_phase == P_RST)  begin if (m_el == PRST - 1) nxt = P_WAIT; end
      else if (m_phase == P_WAIT) begin if (ls) nxt = P_STAB; else if (m_el == TMO - 1) nxt = P_RST; end
      else if (m_phase == P_STAB) begin if (!ls) nxt = P_WAIT; else if (m_el == STB - 1) nxt = P_HOLD; end
      else if (!ls) begin nxt = P_RST; loss = 1'b1; end
      else if (m_phase == P_HOLD && m_el == HLD - 1) nxt = P_RUN;
      m_el    = (sw_reset_req || nxt != m_phase) ? 0 : m_el + 1;
      m_phase = nxt;
      m_pll   = (nxt == P_RST);
      m_mrn   = (nxt == P_RUN);
      m_rdy   = (nxt == P_RUN);
      m_lost  = loss;
      if (clear_count) m_cnt = 0;
      else if (loss && m_cnt < 255) m_cnt = m_cnt + 1;
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   // Stimulus only: hold lock and step until ready rises (0 = not reached).
   task automatic run_until_ready(output int edges);
      locked_in = 1'b1;
      edges = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (mem_reset_n === 1'b1) begin edges = i; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; locked_in = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (dut_v !== 12'h800) begin
         n_bad++; $display("FAIL reset_values got=%h exp=%h", dut_v, 12'h800);
      end
      n_cmp++;
      if (dut_v !== m_v) begin n_bad++; $display("FAIL reset_model got=%h exp=%h", dut_v, m_v); end
   endtask

   task automatic test_power_up();
      int n;
      reset_n = 1'b1;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL pwr_lockstep got=%h exp=%h", dut_v, m_v); end
         if (pll_rst === 1'b0) begin n = i; break; end
      end
      n_cmp++;
      if (n != PRST) begin n_bad++; $display("FAIL pwr_pll_rst_len got=%0d exp=%0d", n, PRST); end
      locked_in = 1'b1;   // first cycle of WAIT_LOCK
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL pwr_lockstep got=%h exp=%h", dut_v, m_v); end
         if (mem_reset_n === 1'b1) begin n = i; break; end
      end
      n_cmp++;
      if (n != SYNC + 1 + STB + HLD) begin
         n_bad++; $display("FAIL pwr_release_latency got=%0d exp=%0d", n, SYNC + 1 + STB + HLD);
      end
      n_cmp++;
      if ({ready, loss_count} !== 9'h100) begin
         n_bad++; $display("FAIL pwr_ready_count got=%h exp=%h", {ready, loss_count}, 9'h100);
      end
   endtask

   task automatic test_stable_glitch();
      int n;
      bit lost_seen;
      sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
      for (int i = 0; i < 20 && m_phase != P_STAB; i++) tick();
      repeat (5) begin
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL glitch_lockstep got=%h exp=%h", dut_v, m_v); end
      end
      locked_in = 1'b0; tick(); locked_in = 1'b1;
      n = 0; lost_seen = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL glitch_lockstep got=%h exp=%h", dut_v, m_v); end
         if (lock_lost === 1'b1) lost_seen = 1'b1;
         if (mem_reset_n === 1'b1) begin n = i; break; end
      end
      n_cmp++;
      if (n != 15) begin n_bad++; $display("FAIL glitch_release got=%0d exp=%0d", n, 15); end
      n_cmp++;
      if (lost_seen) begin n_bad++; $display("FAIL glitch_lock_lost got=1 exp=0"); end
   endtask

   task automatic test_no_lock();
      int  last_rise, run, rises;
      logic prev;
      bit  bad_side;
      sw_reset_req = 1'b1; locked_in = 1'b0; tick(); sw_reset_req = 1'b0;
      prev = 1'b1; run = 1; last_rise = 0; rises = 0; bad_side = 1'b0;
      for (int i = 1; i <= 150; i++) begin
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL nolock_lockstep got=%h exp=%h", dut_v, m_v); end
         if (mem_reset_n !== 1'b0 || lock_lost !== 1'b0 || loss_count !== 8'd0) bad_side = 1'b1;
         if (pll_rst === 1'b1 && prev === 1'b0) begin
            n_cmp++;
            if (i - last_rise != PRST + TMO) begin
               n_bad++; $display("FAIL nolock_period got=%0d exp=%0d", i - last_rise, PRST + TMO);
            end
            last_rise = i; run = 1; rises++;
         end else if (pll_rst === 1'b1) begin
            run++;
         end else if (prev === 1'b1) begin
            n_cmp++;
            if (run != PRST) begin n_bad++; $display("FAIL nolock_pulse got=%0d exp=%0d", run, PRST); end
         end
         prev = pll_rst;
      end
      n_cmp++;
      if (rises != 4) begin n_bad++; $display("FAIL nolock_rises got=%0d exp=%0d", rises, 4); end
      n_cmp++;
      if (bad_side) begin n_bad++; $display("FAIL nolock_side_outputs got=1 exp=0"); end
   endtask

   task automatic test_lock_loss();
      int e, n, pulses, expc;
      run_until_ready(e);
      n_cmp++;
      if (e == 0) begin n_bad++; $display("FAIL loss_reach_run got=timeout exp=ready"); end
      locked_in = 1'b0; n = 0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL loss_lockstep got=%h exp=%h", dut_v, m_v); end
         if (mem_reset_n === 1'b0) begin n = i; break; end
      end
      n_cmp++;
      if (n != SYNC + 1) begin n_bad++; $display("FAIL loss_latency got=%0d exp=%0d", n, SYNC + 1); end
      n_cmp++;
      if ({ready, lock_lost, loss_count} !== 10'h101) begin
         n_bad++; $display("FAIL loss_first got=%h exp=%h", {ready, lock_lost, loss_count}, 10'h101);
      end
      locked_in = 1'b1; tick();
      n_cmp++;
      if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL loss_pulse_width got=%b exp=0", lock_lost); end
      pulses = 0;
      for (int k = 2; k <= 300; k++) begin
         run_until_ready(e);
         locked_in = 1'b0;
         repeat (SYNC + 1) begin
            tick();
            if (lock_lost === 1'b1) pulses++;
            n_cmp++;
            if (dut_v !== m_v) begin n_bad++; $display("FAIL loss_lockstep got=%h exp=%h", dut_v, m_v); end
         end
         locked_in = 1'b1; tick();
         if (lock_lost === 1'b1) pulses++;
         expc = (k > 255) ? 255 : k;
         if (k == 254 || k == 255 || k == 256 || k == 300) begin
            n_cmp++;
            if (loss_count !== 8'(expc)) begin
               n_bad++; $display("FAIL loss_count_%0d got=%0d exp=%0d", k, loss_count, expc);
            end
         end
      end
      n_cmp++;
      if (pulses != 299) begin n_bad++; $display("FAIL loss_pulses got=%0d exp=%0d", pulses, 299); end
   endtask

   task automatic test_clear_and_sw();
      int e;
      bit lost_seen;
      run_until_ready(e);
      locked_in = 1'b0; tick(); tick();
      clear_count = 1'b1; tick(); clear_count = 1'b0;
      n_cmp++;
      if ({mem_reset_n, lock_lost, loss_count} !== 10'h100) begin
         n_bad++; $display("FAIL clear_vs_loss got=%h exp=%h", {mem_reset_n, lock_lost, loss_count}, 10'h100);
      end
      run_until_ready(e);
      locked_in = 1'b0; repeat (SYNC + 1) tick();
      n_cmp++;
      if (loss_count !== 8'd1) begin n_bad++; $display("FAIL clear_recount got=%0d exp=1", loss_count); end
      run_until_ready(e);
      locked_in = 1'b0; tick(); tick();
      sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
      n_cmp++;
      if ({pll_rst, ready, lock_lost, loss_count} !== 11'h401) begin
         n_bad++; $display("FAIL sw_over_loss got=%h exp=%h", {pll_rst, ready, lock_lost, loss_count}, 11'h401);
      end
      lost_seen = 1'b0;
      repeat (4) begin
         tick();
         if (lock_lost === 1'b1) lost_seen = 1'b1;
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL sw_lockstep got=%h exp=%h", dut_v, m_v); end
      end
      n_cmp++;
      if (lost_seen) begin n_bad++; $display("FAIL sw_lock_lost got=1 exp=0"); end
      run_until_ready(e);
      sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
      n_cmp++;
      if ({pll_rst, mem_reset_n, ready, lock_lost, loss_count} !== 12'h801) begin
         n_bad++; $display("FAIL sw_in_run got=%h exp=%h", dut_v, 12'h801);
      end
   endtask

   task automatic test_reset_mid_hold();
      int n;
      locked_in = 1'b1;
      for (int i = 0; i < 200 && m_phase != P_HOLD; i++) tick();
      tick(); tick();
      reset_n = 1'b0; tick();
      n_cmp++;
      if (dut_v !== 12'h800) begin n_bad++; $display("FAIL hold_reset got=%h exp=%h", dut_v, 12'h800); end
      reset_n = 1'b1; n = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL hold_lockstep got=%h exp=%h", dut_v, m_v); end
         if (mem_reset_n === 1'b1) begin n = i; break; end
      end
      n_cmp++;
      if (n != PRST + 1 + STB + HLD) begin
         n_bad++; $display("FAIL hold_resequence got=%0d exp=%0d", n, PRST + 1 + STB + HLD);
      end
   endtask

   task automatic test_random();
      int run_left;
      run_left = 0;
      for (int i = 0; i < 4000; i++) begin
         if (run_left == 0) begin
            locked_in = ~locked_in;
            run_left  = (locked_in) ? $urandom_range(1, 60) : $urandom_range(1, 12);
         end
         run_left--;
         sw_reset_req = ($urandom_range(0, 63) == 0);
         clear_count  = ($urandom_range(0, 63) == 0);
         reset_n      = ($urandom_range(0, 255) != 0);
         tick();
         n_cmp++;
         if (dut_v !== m_v) begin n_bad++; $display("FAIL rand_lockstep i=%0d got=%h exp=%h", i, dut_v, m_v); end
      end
      sw_reset_req = 1'b0; clear_count = 1'b0; reset_n = 1'b1;
   endtask

   initial begin
      repeat (SYNC) m_sync.push_back(1'b0);
      #1;
      test_reset();
      test_power_up();
      test_stable_glitch();
      test_no_lock();
      test_lock_loss();
      test_clear_and_sw();
      test_reset_mid_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
